// File: rtl/payload_engine_seq.sv
`timescale 1ns/1ps
// Packet sequencer for a bank of payload regex engines: clears the bank, streams the
// payload bytes, waits for the engine pipeline to drain, then reports every matching engine.
module payload_engine_seq #(
    parameter int NUM_ENG = 16,
    parameter int ID_W    = 4,
    parameter int DRAIN   = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [7:0]         in_data,
    input  logic               in_valid,
    input  logic               in_sop,
    input  logic               in_eop,
    output logic               in_ready,
    output logic               eng_sod,
    output logic               eng_en,
    output logic [7:0]         eng_char,
    input  logic [NUM_ENG-1:0] eng_match,
    output logic               res_valid,
    output logic [ID_W-1:0]    res_id,
    output logic               res_none,
    output logic               res_last,
    input  logic               res_ready,
    output logic               err,
    output logic               busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_SCAN,
        S_DRAIN,
        S_REPORT
    } state_t;

    state_t             r_state;
    logic [3:0]         r_cnt;
    logic               r_first;
    logic [NUM_ENG-1:0] r_snap;
    logic               r_eng_sod;
    logic               r_eng_en;
    logic [7:0]         r_eng_char;
    logic               r_res_valid;
    logic [ID_W-1:0]    r_res_id;
    logic               r_res_none;
    logic               r_res_last;
    logic               r_err;

    logic               w_in_ready;
    logic               w_accept;
    logic               w_res_fire;

    function automatic logic [ID_W-1:0] f_lowest(input logic [NUM_ENG-1:0] v);
        logic [ID_W-1:0] id;
        id = '0;
        for (int i = NUM_ENG - 1; i >= 0; i--) begin
            if (v[i]) id = ID_W'(i);
        end
        return id;
    endfunction

    function automatic logic [NUM_ENG-1:0] f_drop_lowest(input logic [NUM_ENG-1:0] v);
        return v & (v - NUM_ENG'(1));
    endfunction

    always_comb begin
        w_in_ready = 1'b0;
        case (r_state)
            S_IDLE:  w_in_ready = ~in_sop;
            S_SCAN:  w_in_ready = 1'b1;
            default: w_in_ready = 1'b0;
        endcase
    end

    assign w_accept   = in_valid & w_in_ready;
    assign w_res_fire = r_res_valid & res_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_first     <= 1'b0;
            r_snap      <= '0;
            r_eng_sod   <= 1'b1;
            r_eng_en    <= 1'b0;
            r_eng_char  <= '0;
            r_res_valid <= 1'b0;
            r_res_id    <= '0;
            r_res_none  <= 1'b0;
            r_res_last  <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_eng_sod <= 1'b0;
            r_eng_en  <= 1'b0;
            r_err     <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    // A sop beat is left on the bus so SCAN consumes it as byte 0.
                    if (in_valid && in_sop) begin
                        r_state   <= S_CLEAR;
                        r_eng_sod <= 1'b1;
                    end else if (in_valid) begin
                        r_err <= 1'b1;
                    end
                end
                S_CLEAR: begin
                    r_state <= S_SCAN;
                    r_first <= 1'b1;
                end
                S_SCAN: begin
                    if (w_accept) begin
                        r_eng_en   <= 1'b1;
                        r_eng_char <= in_data;
                        r_first    <= 1'b0;
                        if (in_sop && !r_first) r_err <= 1'b1;
                        if (in_eop) begin
                            r_state <= S_DRAIN;
                            r_cnt   <= 4'(DRAIN - 1);
                        end
                    end
                end
                S_DRAIN: begin
                    if (r_cnt == '0) begin
                        r_state     <= S_REPORT;
                        r_res_valid <= 1'b1;
                        r_res_id    <= f_lowest(eng_match);
                        r_res_none  <= (eng_match == '0);
                        r_res_last  <= (f_drop_lowest(eng_match) == '0);
                        r_snap      <= f_drop_lowest(eng_match);
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                S_REPORT: begin
                    // r_snap holds only the bits not yet presented on the result port.
                    if (w_res_fire) begin
                        if (r_res_last) begin
                            r_state     <= S_IDLE;
                            r_res_valid <= 1'b0;
                            r_res_id    <= '0;
                            r_res_none  <= 1'b0;
                            r_res_last  <= 1'b0;
                        end else begin
                            r_res_id   <= f_lowest(r_snap);
                            r_snap     <= f_drop_lowest(r_snap);
                            r_res_last <= (f_drop_lowest(r_snap) == '0);
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = w_in_ready;
    assign eng_sod   = r_eng_sod;
    assign eng_en    = r_eng_en;
    assign eng_char  = r_eng_char;
    assign res_valid = r_res_valid;
    assign res_id    = r_res_id;
    assign res_none  = r_res_none;
    assign res_last  = r_res_last;
    assign err       = r_err;
    assign busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_payload_engine_seq.sv
`timescale 1ns/1ps
// Bench for payload_engine_seq: directed scenarios plus random packets, with a
// behavioural engine bank and packet-level scoreboard.
module tb_payload_engine_seq;

    localparam int NUM_ENG = 16;
    localparam int ID_W    = 4;
    localparam int DRAIN   = 2;

    typedef struct packed {
        logic [3:0] id;
        logic       none;
        logic       last;
    } res_t;

    typedef struct packed {
        logic [7:0]  len;
        logic [15:0] mask;
    } pkt_t;

    logic               clk = 1'b0;
    logic               rst;
    logic [7:0]         in_data;
    logic               in_valid;
    logic               in_sop;
    logic               in_eop;
    logic               in_ready;
    logic               eng_sod;
    logic               eng_en;
    logic [7:0]         eng_char;
    logic [NUM_ENG-1:0] eng_match;
    logic               res_valid;
    logic [ID_W-1:0]    res_id;
    logic               res_none;
    logic               res_last;
    logic               res_ready;
    logic               err;
    logic               busy;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] exp_bytes[$];
    logic [7:0] got_bytes[$];
    res_t       exp_res[$];
    res_t       got_res[$];
    pkt_t       pend[$];
    int         exp_sod = 0, sod_cnt = 0;
    int         exp_err = 0, err_cnt = 0;
    int         rdy_mode = 0;

    logic [15:0] m_mask;
    int          m_len, m_cnt;

    always #5 clk = ~clk;

    payload_engine_seq #(.NUM_ENG(NUM_ENG), .ID_W(ID_W), .DRAIN(DRAIN)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_sop(in_sop),
        .in_eop(in_eop), .in_ready(in_ready), .eng_sod(eng_sod), .eng_en(eng_en),
        .eng_char(eng_char), .eng_match(eng_match), .res_valid(res_valid), .res_id(res_id),
        .res_none(res_none), .res_last(res_last), .res_ready(res_ready), .err(err), .busy(busy)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Engine bank: sticky bits become the packet's target mask once its last byte is processed.
    always @(posedge clk) begin
        if (eng_sod) begin
            eng_match <= '0;
            m_cnt     <= 0;
            if (pend.size() > 0) begin
                m_len  <= int'(pend[0].len);
                m_mask <= pend[0].mask;
                void'(pend.pop_front());
            end else begin
                m_len  <= 0;
                m_mask <= '0;
            end
        end else if (eng_en) begin
            m_cnt <= m_cnt + 1;
            if (m_cnt + 1 == m_len) eng_match <= m_mask;
        end
    end

    initial begin
        res_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            case (rdy_mode)
                0:       res_ready = 1'b1;
                1:       res_ready = ~res_ready;
                default: res_ready = ($urandom_range(0, 2) != 0);
            endcase
        end
    end

    initial begin : monitor
        logic       stall_q;
        logic [6:0] prev;
        stall_q = 1'b0;
        prev    = '0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (eng_en) got_bytes.push_back(eng_char);
                if (eng_sod) sod_cnt++;
                if (err) err_cnt++;
                if (res_valid) chk("ready_in_report", in_ready, 0);
                if (stall_q) chk("stall_hold", {res_valid, res_id, res_none, res_last}, prev);
                if (res_valid && res_ready) got_res.push_back({res_id, res_none, res_last});
                stall_q = res_valid && !res_ready;
                prev    = {res_valid, res_id, res_none, res_last};
            end else begin
                stall_q = 1'b0;
            end
        end
    end

    task automatic add_exp(input logic [15:0] mask);
        int ids[$];
        for (int i = 0; i < NUM_ENG; i++) if (mask[i]) ids.push_back(i);
        if (ids.size() == 0) exp_res.push_back({4'd0, 1'b1, 1'b1});
        foreach (ids[k]) exp_res.push_back({4'(ids[k]), 1'b0, (k == ids.size() - 1)});
    endtask

    task automatic clear_sb();
        exp_bytes.delete(); got_bytes.delete(); exp_res.delete(); got_res.delete();
        exp_sod = 0; sod_cnt = 0; exp_err = 0; err_cnt = 0;
    endtask

    task automatic send_pkt(input logic [7:0] d[$], input logic [15:0] mask, input int xsop,
                            input bit gaps, input bit hold);
        int i = 0;
        int guard = 0;
        pend.push_back({8'(d.size()), mask});
        foreach (d[k]) exp_bytes.push_back(d[k]);
        add_exp(mask);
        exp_sod++;
        if (xsop > 0) exp_err++;
        while (i < d.size()) begin
            @(posedge clk); #1;
            in_valid = !(gaps && $urandom_range(0, 3) == 0);
            in_data  = d[i];
            in_sop   = (i == 0) || (i == xsop);
            in_eop   = (i == d.size() - 1);
            #1;
            if (in_valid && in_ready) i++;
            if (++guard > 2000) begin
                chk("send_timeout", 0, 1);
                break;
            end
        end
        @(posedge clk); #1;
        if (!hold) begin
            in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
        end
    endtask

    task automatic wait_idle();
        int g = 0;
        while (busy !== 1'b0) begin
            @(posedge clk); #1;
            if (++g > 1000) begin
                chk("idle_timeout", 0, 1);
                break;
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic verify(input string tag);
        chk({tag, "_nbytes"}, got_bytes.size(), exp_bytes.size());
        for (int k = 0; k < exp_bytes.size() && k < got_bytes.size(); k++)
            chk({tag, "_byte"}, got_bytes[k], exp_bytes[k]);
        chk({tag, "_sod"}, sod_cnt, exp_sod);
        chk({tag, "_err"}, err_cnt, exp_err);
        chk({tag, "_nres"}, got_res.size(), exp_res.size());
        for (int k = 0; k < exp_res.size() && k < got_res.size(); k++)
            chk({tag, "_res"}, got_res[k], exp_res[k]);
        clear_sb();
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic [7:0] pk[$];
        int g;
        rst = 1'b0; in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0; in_data = '0;

        // Power-on reset.
        #1 rst = 1'b1; #1;
        chk("rst_sod", eng_sod, 1);
        chk("rst_busy", busy, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_eng_en", eng_en, 0);
        chk("rst_err", err, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        chk("rel_sod", eng_sod, 0);
        chk("rel_busy", busy, 0);
        clear_sb();

        // Reset in the middle of SCAN.
        in_valid = 1'b1; in_sop = 1'b1; in_data = 8'h11;
        repeat (3) @(posedge clk);
        #1 in_sop = 1'b0; in_data = 8'h22;
        chk("mid_busy_before", busy, 1);
        #2 rst = 1'b1; #1;
        chk("mid_rst_sod", eng_sod, 1);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_res_valid", res_valid, 0);
        chk("mid_rst_eng_en", eng_en, 0);
        @(posedge clk); #1 rst = 1'b0; in_valid = 1'b0;
        @(posedge clk); #1;
        chk("mid_rel_sod", eng_sod, 0);
        chk("mid_rel_busy", busy, 0);
        pend.delete();
        clear_sb();

        // "sin12", no match.
        rdy_mode = 0;
        pk = '{8'h73, 8'h69, 8'h6e, 8'h31, 8'h32};
        send_pkt(pk, 16'h0000, -1, 1'b0, 1'b0);
        wait_idle();
        verify("sin12");

        // Three matches with a stalling consumer.
        rdy_mode = 1;
        pk = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
        send_pkt(pk, 16'h8021, -1, 1'b0, 1'b0);
        wait_idle();
        verify("m8021");

        // Single-byte packet latency.
        rdy_mode = 0;
        pend.push_back({8'd1, 16'h0400});
        exp_bytes.push_back(8'h5A);
        add_exp(16'h0400);
        exp_sod = 1;
        @(posedge clk); #1;
        in_valid = 1'b1; in_sop = 1'b1; in_eop = 1'b1; in_data = 8'h5A;
        #1;
        g = 0;
        while (!in_ready && g < 50) begin
            @(posedge clk); #2;
            g++;
        end
        chk("sb_wait_cycles", g, 2);
        @(posedge clk); #1;
        in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
        chk("sb_en", eng_en, 1);
        chk("sb_char", eng_char, 8'h5A);
        chk("sb_valid_a1", res_valid, 0);
        @(posedge clk); #1;
        chk("sb_valid_a2", res_valid, 0);
        @(posedge clk); #1;
        chk("sb_valid_a3", res_valid, 1);
        chk("sb_id", res_id, 10);
        chk("sb_last", res_last, 1);
        wait_idle();
        verify("single");

        // Stray beat in IDLE.
        @(posedge clk); #1;
        in_valid = 1'b1; in_sop = 1'b0; in_data = 8'h77;
        #1 chk("stray_ready", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("stray_err", err, 1);
        chk("stray_en", eng_en, 0);
        chk("stray_busy", busy, 0);
        @(posedge clk); #1;
        chk("stray_err_clr", err, 0);
        exp_err = 1;
        verify("stray");

        // Sop inside SCAN is streamed as data and flagged.
        pk = '{8'hA0, 8'hA1, 8'hA2, 8'hA3};
        send_pkt(pk, 16'h0002, 2, 1'b0, 1'b0);
        wait_idle();
        verify("xsop");

        // Back-to-back with in_valid held high.
        rdy_mode = 2;
        pk = '{8'hB0, 8'hB1, 8'hB2};
        send_pkt(pk, 16'h0101, -1, 1'b0, 1'b1);
        pk = '{8'hC0, 8'hC1};
        send_pkt(pk, 16'h4000, -1, 1'b0, 1'b0);
        wait_idle();
        verify("b2b");

        // Random packets.
        for (int n = 0; n < 30; n++) begin
            int len;
            logic [15:0] mk;
            bit hold;
            len  = $urandom_range(1, 12);
            mk   = ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom);
            hold = (n < 29) && ($urandom_range(0, 2) == 0);
            rdy_mode = $urandom_range(0, 2);
            pk.delete();
            for (int k = 0; k < len; k++) pk.push_back(8'($urandom));
            send_pkt(pk, mk, -1, 1'($urandom_range(0, 1)), hold);
            if (!hold) begin
                wait_idle();
                verify("rand");
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
